swd_host: RTL

SWD_HOST -- requirements
Module: swd_host

---
 rtl/swd_host_pkg.sv | 51 +++++
 rtl/swd_host_if.sv | 35 +++
 rtl/swd_host_clkgen.sv | 48 ++++
 rtl/swd_host.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/swd_host_pkg.sv
//------------------------------------------------------------------------------
// Module  : swd_host_pkg
// Brief   : Shared types and constants for the SWD host: FSM state encoding,
//           ACK codes, phase lengths and the request-header builder.
//           Build option: SWD_HOST_LINE_RESET_EN adds the LRST state.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package swd_host_pkg;

  typedef logic [2:0] swd_ack_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    REQ   = 4'd1,
    TRN1  = 4'd2,
    ACK   = 4'd3,
    RDATA = 4'd4,
    WDATA = 4'd5,
    TRN2  = 4'd6,
    TAIL  = 4'd7
`ifdef SWD_HOST_LINE_RESET_EN
    ,
    LRST  = 4'd8
`endif
  } state_t;

  localparam swd_ack_t ACK_OK    = 3'b001;
  localparam swd_ack_t ACK_WAIT  = 3'b010;
  localparam swd_ack_t ACK_FAULT = 3'b100;

  // Phase lengths in SWCLK cycles
  localparam int unsigned REQ_LEN      = 8;
  localparam int unsigned ACK_LEN      = 3;
  localparam int unsigned DATA_LEN     = 33;
  localparam int unsigned TAIL_LEN     = 8;
  localparam int unsigned LRST_LEN     = 56;
  localparam int unsigned LRST_LOW_LEN = 8;

  // Request header, bit 0 is sent first:
  // start, APnDP, RnW, A2, A3, even parity, stop, park
  function automatic logic [7:0] req_header(input logic       apndp,
                                            input logic       rnw,
                                            input logic [1:0] addr);
    return {1'b1, 1'b0, ^{apndp, rnw, addr}, addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/swd_host_if.sv
//------------------------------------------------------------------------------
// Module  : swd_host_if
// Brief   : Request/response bus between a requester and the SWD host.
//           master = requester side, slave = SWD host side.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface swd_host_if;
  import swd_host_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_apndp;
  logic        req_rnw;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  swd_ack_t    rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;

  modport master (
    output req_valid, req_apndp, req_rnw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
  );

  modport slave (
    input  req_valid, req_apndp, req_rnw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
  );

endinterface

`default_nettype wire

// File: rtl/swd_host_clkgen.sv
//------------------------------------------------------------------------------
// Module  : swd_host_clkgen
// Brief   : SWCLK divider. Each half period lasts CLK_DIV sysclk cycles; the
//           rise/fall strobes are high in the sysclk cycle whose closing edge
//           toggles SWCLK. SWCLK is held low while run is low.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module swd_host_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic run,
  output logic swclk,
  output logic rise,
  output logic fall
);

  logic [7:0] r_div_cnt;
  logic       r_swclk;
  logic       w_wrap;

  assign w_wrap = run && (r_div_cnt == 8'(CLK_DIV - 1));
  assign rise   = w_wrap && !r_swclk;
  assign fall   = w_wrap && r_swclk;
  assign swclk  = r_swclk;

  // Half-period counter; SWCLK parks low and the count restarts when idle
  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      r_div_cnt <= 8'd0;
      r_swclk   <= 1'b0;
    end else if (!run) begin
      r_div_cnt <= 8'd0;
      r_swclk   <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= 8'd0;
      r_swclk   <= ~r_swclk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/swd_host.sv
//------------------------------------------------------------------------------
// Module  : swd_host
// Brief   : Serial Wire Debug host. Runs one SWD transaction per accepted
//           request: header, turnaround, ACK, then read data (with parity
//           check) or write data, followed by idle tail cycles.
//           Build option: SWD_HOST_LINE_RESET_EN adds the line_reset input
//           and the LRST line-reset sequence (56 high + 8 low SWCLK).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module swd_host
  import swd_host_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       sysclk,
  input  logic       sysrst,
  swd_host_if.slave  bus,
  output logic       SWCLK,
  output logic       SWDIO_o,
  output logic       SWDIO_oe,
  input  logic       SWDIO_i
`ifdef SWD_HOST_LINE_RESET_EN
  ,
  input  logic       line_reset
`endif
);

  state_t      r_state;
  logic [5:0]  r_cnt;      // bit index within the current phase
  logic [32:0] r_tx;       // outgoing bits, r_tx[0] is on the wire
  logic [32:0] r_rx;       // incoming read data, parity ends up in bit 32
  logic [31:0] r_wdata;
  logic        r_rnw;
  swd_ack_t    r_ack;
  logic        r_oe;
  logic        r_ready;
  logic        r_rsp_valid;
  swd_ack_t    r_rsp_ack;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_perr;

  logic        w_run;
  logic        w_rise;
  logic        w_fall;
  logic [7:0]  w_hdr;

  assign w_run = (r_state != IDLE);
  assign w_hdr = req_header(bus.req_apndp, bus.req_rnw, bus.req_addr);

  swd_host_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .sysclk (sysclk),
    .sysrst (sysrst),
    .run    (w_run),
    .swclk  (SWCLK),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  assign SWDIO_o       = r_tx[0];
  assign SWDIO_oe      = r_oe;
  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_ack   = r_rsp_ack;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_perr  = r_rsp_perr;

  // Transaction FSM: outputs change on fall strobes, SWDIO_i is taken on rise
  // strobes. Each phase slot is one SWCLK cycle (low half then high half).
  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      r_state     <= IDLE;
      r_cnt       <= 6'd0;
      r_tx        <= 33'd0;
      r_rx        <= 33'd0;
      r_wdata     <= 32'd0;
      r_rnw       <= 1'b0;
      r_ack       <= 3'd0;
      r_oe        <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_ack   <= 3'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_perr  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_oe  <= 1'b1;
          r_cnt <= 6'd0;
          r_tx  <= 33'd0;
`ifdef SWD_HOST_LINE_RESET_EN
          if (line_reset) begin
            r_state <= LRST;
            r_ready <= 1'b0;
            r_tx    <= 33'd1;
          end else
`endif
          if (bus.req_valid && r_ready) begin
            // Bit 0 of the header goes out now; SWCLK is low for a full
            // half period before the target's first sampling edge.
            r_state <= REQ;
            r_ready <= 1'b0;
            r_tx    <= {25'd0, w_hdr};
            r_rnw   <= bus.req_rnw;
            r_wdata <= bus.req_wdata;
          end else begin
            r_ready <= 1'b1;
          end
        end

        REQ: if (w_fall) begin
          if (r_cnt == 6'(REQ_LEN - 1)) begin
            r_state <= TRN1;
            r_cnt   <= 6'd0;
            r_oe    <= 1'b0;
            r_tx    <= 33'd0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            r_tx  <= {1'b0, r_tx[32:1]};
          end
        end

        TRN1: if (w_fall) begin
          r_state <= ACK;
          r_cnt   <= 6'd0;
        end

        ACK: begin
          if (w_rise) begin
            r_ack <= {SWDIO_i, r_ack[2:1]};
          end
          if (w_fall) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(ACK_LEN - 1)) begin
              r_cnt <= 6'd0;
              if (r_ack == ACK_OK && r_rnw) begin
                r_state <= RDATA;
              end else begin
                r_state <= TRN2;
              end
            end
          end
        end

        RDATA: begin
          if (w_rise) begin
            r_rx <= {SWDIO_i, r_rx[32:1]};
          end
          if (w_fall) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(DATA_LEN - 1)) begin
              r_state <= TRN2;
              r_cnt   <= 6'd0;
            end
          end
        end

        // Shared turnaround: a good read completes here, a good write goes on
        // to drive data, anything else runs the idle tail.
        TRN2: if (w_fall) begin
          r_cnt <= 6'd0;
          r_oe  <= 1'b1;
          if (r_ack == ACK_OK && r_rnw) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_ack   <= r_ack;
            r_rsp_rdata <= r_rx[31:0];
            r_rsp_perr  <= r_rx[32] ^ (^r_rx[31:0]);
          end else if (r_ack == ACK_OK) begin
            r_state <= WDATA;
            r_tx    <= {^r_wdata, r_wdata};
          end else begin
            r_state <= TAIL;
            r_tx    <= 33'd0;
          end
        end

        WDATA: if (w_fall) begin
          if (r_cnt == 6'(DATA_LEN - 1)) begin
            r_state <= TAIL;
            r_cnt   <= 6'd0;
            r_tx    <= 33'd0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            r_tx  <= {1'b0, r_tx[32:1]};
          end
        end

        TAIL: if (w_fall) begin
          if (r_cnt == 6'(TAIL_LEN - 1)) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_ack   <= r_ack;
            r_rsp_perr  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

`ifdef SWD_HOST_LINE_RESET_EN
        LRST: if (w_fall) begin
          if (r_cnt == 6'(LRST_LEN + LRST_LOW_LEN - 1)) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            r_tx        <= 33'd0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_ack   <= 3'd0;
            r_rsp_perr  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            r_tx  <= {32'd0, (r_cnt < 6'(LRST_LEN - 1))};
          end
        end
`endif

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
